fnd_scan_ctrl: RTL and testbench
================================

# fnd_scan_ctrl

Time-multiplexed scan controller for the 4-digit common-anode FND. It owns the single shared hex-to-7-segment decoder and steps it through four nibbles of a 16-bit display value, one digit at a time. It inserts a blanking gap between digits against ghosting, and accepts new values through a valid/ready handshake. New values commit only at frame boundaries, so a number never tears across digits. It sits between the adder result register and the board's segment/anode pins.

## Interface

- SCAN_DIV, default 100000: cycles each digit is driven; legal range ≥ 2.
- BLANK_CYC, default 1000: cycles all anodes are off before each digit; legal range ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- din  in  16  display value; nibble k → digit k (digit 0 is rightmost).
- din_valid  in  1  offer of din.
- din_ready  out  1  high when no value is pending; transfer occurs when din_valid & din_ready.
- dp_in  in  4  decimal point request per digit, active-high.
- lz_en  in  1  leading-zero suppression enable.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- an  out  4  anode enables, active-low, one-hot-low when driving.
- frame_tick  out  1  one-cycle pulse at the end of each 4-digit frame.

## Operation

- One clock domain (clk); reset is synchronous and active-high on rst.
- Registers:
  - disp (committed value, 16 bits)
  - pend_val / pend (pending value and flag)
  - digit index (2 bits)
  - phase counter
  - state
- FSM states:
  - BLANK: an=4'hF, seg=7'h7F, dp=1. Lasts BLANK_CYC cycles, then goes to DRIVE.
  - DRIVE: an[digit]=0, all other an bits 1. Lasts SCAN_DIV cycles.
    - At the end of DRIVE with digit<3: digit+1, then BLANK.
    - At the end of DRIVE with digit==3: digit wraps to 0, frame_tick pulses, pending commit occurs, then BLANK.
- Decoding: seg = active-low code of disp[4*digit+:4]. The code table is the standard hex table:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→58
  - 8→00, 9→10, A→20, B→03, C→27, D→21, E→04, F→0E (hex, 7-bit).
- Decimal point: dp = ~dp_in[digit], sampled during DRIVE. dp is not affected by zero suppression.
- Leading-zero suppression: when lz_en=1, digit k (k=3,2,1) shows seg=7'h7F if nibbles 3..k of disp are all zero. Digit 0 is never suppressed, so value 0 shows a single "0".
- Handshake:
  - din_ready = ~pend.
  - On transfer, pend_val←din and pend←1.
  - At frame end, if pend was set before that cycle: disp←pend_val and pend←0.
  - A transfer in the frame-end cycle itself sets pend and commits at the next frame end.
- dp_in and lz_en are live inputs; they are not held by the handshake.

## Timing

- All outputs (seg, dp, an, frame_tick) are registered.
- Pins lag the FSM by exactly 1 cycle.
- Frame length is 4·(BLANK_CYC+SCAN_DIV) cycles.
- In steady state, each an bit is low for exactly SCAN_DIV consecutive cycles per frame. It is separated from the adjacent digit by exactly BLANK_CYC cycles of an=4'hF.
- seg and an change on the same edge; seg is never non-blank while an=4'hF.
- Reset (rst high at an edge) produces, on the next cycle:
  - an=4'hF, seg=7'h7F, dp=1, frame_tick=0, din_ready=1
  - disp=0, pend=0, digit=0, state=BLANK, counter=0.
- Reset mid-frame aborts the frame immediately and discards any pending value.
- First digit after reset: an=4'b1110 for the first time BLANK_CYC+1 cycles after rst deasserts.
- frame_tick is high for 1 cycle, coincident with the first BLANK cycle of the next frame on the pins.
- Latency from a transfer to display: at most one frame plus 1 cycle. din_ready stays low from the cycle after the transfer until the cycle after the commit.

## Test plan

All scenarios use SCAN_DIV=4, BLANK_CYC=2, so the frame is 24 cycles.

- **Reset:** hold rst 3 cycles, then release → an=F and seg=7F for 2 cycles. Then an=E, seg=40 for 4 cycles. Then 2 blank cycles, then an=D. frame_tick first pulses 24 cycles after release.
- **Scan and decode:** transfer din=16'h1234 with lz_en=0 → after the next frame_tick, digits 0..3 show seg=19,30,24,79 in order. Check an one-hot-low, each digit driven for 4 cycles, 2-cycle blank gaps.
- **Handshake and back-pressure:** transfer 16'hABCD, then hold din_valid with 16'h5678 → din_ready stays 0 until the cycle after the frame end. 5678 is accepted only after ABCD is displayed, and no value is lost or reordered.
- **Zero suppression:** lz_en=1.
  - disp=16'h0070 → digits 3,2 show 7F; digit 1 shows 58; digit 0 shows 40.
  - disp=0 → digits 3..1 show 7F; digit 0 shows 40.
  - dp_in=4'b1000 with disp=0 → dp=0 during digit 3 only.
- **Frame-end collision:** transfer exactly on the frame_tick cycle → not displayed in the following frame; displayed after the next frame_tick.
- **Reset mid-drive:** assert rst while an=4'b1011 with a value pending → next cycle: an=F, seg=7F, din_ready=1. The old pending value never appears on the display.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// Scan controller for a 4-digit common-anode FND: blanks, drives and decodes one
// digit at a time, and takes new display values only at frame boundaries.
module fnd_scan_ctrl #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [3:0]  dp_in,
  input  logic        lz_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV - 1);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    digit;
  logic [15:0]   disp;
  logic [15:0]   pend_val;
  logic          pend;
  logic          tick_int;

  logic [3:0]    nib;
  logic [15:0]   upper;
  logic [6:0]    code;
  logic          suppress;
  logic          frame_end;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h58;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h20;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h27;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h04;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    nib       = disp[{digit, 2'b00} +: 4];
    upper     = disp >> {digit, 2'b00};
    code      = hex7(nib);
    suppress  = lz_en && (digit != 2'd0) && (upper == 16'h0000);
    frame_end = (state == DRIVE) && (cnt == SCAN_LAST) && (digit == 2'd3);
  end

  assign din_ready = ~pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      digit      <= 2'd0;
      disp       <= 16'h0000;
      pend_val   <= 16'h0000;
      pend       <= 1'b0;
      tick_int   <= 1'b0;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      // Pins are a registered image of the current state, one cycle behind it.
      tick_int   <= frame_end;
      frame_tick <= tick_int;
      if (state == DRIVE) begin
        an  <= ~(4'b0001 << digit);
        seg <= suppress ? 7'h7F : code;
        dp  <= ~dp_in[digit];
      end else begin
        an  <= 4'hF;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end

      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= DRIVE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == SCAN_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
            state <= BLANK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase

      // Commit and accept are exclusive: a transfer needs pend low, a commit needs it high.
      if (frame_end && pend) begin
        disp <= pend_val;
        pend <= 1'b0;
      end else if (din_valid && !pend) begin
        pend_val <= din;
        pend     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl: transfers queue the value and the frame in
// which it must first appear; a pin monitor checks every cycle against that.
module tb_fnd_scan_ctrl;

  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int FRAME = 4 * (SD + BC);
  localparam int SLOT  = SD + BC;
  localparam logic [6:0] HEX_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h58,
    7'h00, 7'h10, 7'h20, 7'h03, 7'h27, 7'h21, 7'h04, 7'h0E
  };

  typedef struct {
    logic [15:0] val;
    int          ff;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'h0000;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [3:0]  dp_in = 4'h0;
  logic        lz_en = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  entry_t      sb[$];
  int          checks = 0;
  int          failures = 0;
  int          k = -1;
  bit          started = 1'b0;
  logic [15:0] cur_disp = 16'h0000;
  logic        lz_s = 1'b0;
  logic [3:0]  dp_s = 4'h0;

  fnd_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dp_in(dp_in), .lz_en(lz_en), .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    end
  endtask

  // Cycle position since reset release, plus the live inputs as the DUT sampled them.
  always @(posedge clk) begin
    lz_s <= lz_en;
    dp_s <= dp_in;
    if (rst) begin
      started <= 1'b1;
      k       <= -1;
    end else if (started) begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    int          q, d, r;
    logic [15:0] up;
    logic [3:0]  nb;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_dp, exp_rdy;
    if (started) begin
      if (k < 0) begin
        sb.delete();
        cur_disp = 16'h0000;
        checkOutput("rst_an", 32'(an), 32'hF);
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_dp", 32'(dp), 32'h1);
        checkOutput("rst_tick", 32'(frame_tick), 32'h0);
        checkOutput("rst_ready", 32'(din_ready), 32'h1);
      end else begin
        q = k % FRAME;
        if (q == 0 && k > 0 && sb.size() > 0 && sb[0].ff == k / FRAME) begin
          cur_disp = sb[0].val;
          void'(sb.pop_front());
        end
        d = q / SLOT;
        r = q % SLOT;
        if (r < BC) begin
          exp_an  = 4'hF;
          exp_seg = 7'h7F;
          exp_dp  = 1'b1;
        end else begin
          exp_an  = ~(4'b0001 << d);
          up      = cur_disp >> (4 * d);
          nb      = up[3:0];
          exp_seg = (lz_s && d > 0 && up == 16'h0000) ? 7'h7F : HEX_TBL[nb];
          exp_dp  = ~dp_s[d];
        end
        exp_rdy = !(sb.size() > 0 && (FRAME * sb[sb.size()-1].ff - 1) > k);
        checkOutput("an", 32'(an), 32'(exp_an));
        checkOutput("seg", 32'(seg), 32'(exp_seg));
        checkOutput("dp", 32'(dp), 32'(exp_dp));
        checkOutput("frame_tick", 32'(frame_tick), 32'(k > 0 && q == 0));
        checkOutput("din_ready", 32'(din_ready), 32'(exp_rdy));
      end
    end
  end

  // Called on a falling edge; the transfer lands on the next rising edge.
  task automatic applyStimulus(input logic [15:0] value, input int budget);
    bit     done = 1'b0;
    int     t;
    entry_t e;
    din       = value;
    din_valid = 1'b1;
    for (int i = 0; i < budget && !done; i++) begin
      if (din_ready) begin
        t = k + 1;
        @(posedge clk);
        e.val = value;
        e.ff  = (t + 1) / FRAME + 1;
        sb.push_back(e);
        #1 din_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      din_valid = 1'b0;
      checkOutput("xfer_timeout", 32'h0, 32'h1);
    end
    if (done) @(negedge clk);
  endtask

  task automatic waitForPos(input int target);
    bit done = 1'b0;
    for (int i = 0; i < 3 * FRAME && !done; i++) begin
      @(negedge clk);
      if (k > 0 && k % FRAME == target) done = 1'b1;
    end
    if (!done) checkOutput("wait_pos", 32'h0, 32'h1);
  endtask

  task automatic waitForAn(input logic [3:0] target);
    bit done = 1'b0;
    for (int i = 0; i < 3 * FRAME && !done; i++) begin
      @(negedge clk);
      if (an == target) done = 1'b1;
    end
    if (!done) checkOutput("wait_an", 32'h0, 32'h1);
  endtask

  task automatic waitFrames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    waitFrames(2);

    applyStimulus(16'h1234, 4 * FRAME);
    waitFrames(2);

    applyStimulus(16'hABCD, 4 * FRAME);
    applyStimulus(16'h5678, 4 * FRAME);
    waitFrames(3);

    lz_en = 1'b1;
    applyStimulus(16'h0070, 4 * FRAME);
    waitFrames(2);
    dp_in = 4'b1000;
    applyStimulus(16'h0000, 4 * FRAME);
    waitFrames(2);

    dp_in = 4'b0101;
    lz_en = 1'b0;
    waitForPos(0);
    applyStimulus(16'hBEEF, 4 * FRAME);
    waitFrames(2);
    waitForPos(FRAME - 2);
    applyStimulus(16'hC0DE, 4 * FRAME);
    waitFrames(3);

    lz_en = 1'b1;
    dp_in = 4'b1000;
    waitForPos(0);
    applyStimulus(16'h9999, 4 * FRAME);
    waitForAn(4'b1011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    waitFrames(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("[TB] FAIL watchdog k=%0d got=running exp=finished", k);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
